// File: rtl/keypad_decoder.sv
// 4x4 matrix keypad decoder: captures one key from a walking-zero row scan,
// debounces press and release on the scan tick, and reports the accepted key code.
module keypad_decoder #(
  parameter int unsigned DEBOUNCE_TICKS = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic [3:0] row_drv,
  input  logic [3:0] col_in,
  output logic       scan_en,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held
);

  typedef enum logic [1:0] {SCAN, DEBOUNCE, PRESSED, RELEASE} state_t;

  localparam logic [3:0] DB_TICKS = 4'(DEBOUNCE_TICKS);

  state_t     state_q;
  logic [3:0] cnt_q;
  logic [1:0] row_q;
  logic [1:0] col_q;
  logic [3:0] key_code_q;
  logic       key_valid_q;

  logic       sample_valid;
  logic       sample_match;
  logic       cols_released;
  logic [1:0] row_idx;
  logic [1:0] col_idx;
  logic [3:0] cnt_d;

  // Position of the single low bit; only meaningful when the vector is one-cold.
  function automatic logic [1:0] zero_pos(input logic [3:0] v);
    case (v)
      4'b1101: return 2'd1;
      4'b1011: return 2'd2;
      4'b0111: return 2'd3;
      default: return 2'd0;
    endcase
  endfunction

  function automatic logic [3:0] code_of(input logic [1:0] row, input logic [1:0] col);
    case ({row, col})
      4'b00_00: return 4'h1;
      4'b00_01: return 4'h2;
      4'b00_10: return 4'h3;
      4'b00_11: return 4'hA;
      4'b01_00: return 4'h4;
      4'b01_01: return 4'h5;
      4'b01_10: return 4'h6;
      4'b01_11: return 4'hB;
      4'b10_00: return 4'h7;
      4'b10_01: return 4'h8;
      4'b10_10: return 4'h9;
      4'b10_11: return 4'hC;
      4'b11_00: return 4'hE;
      4'b11_01: return 4'h0;
      4'b11_10: return 4'hF;
      default:  return 4'hD;
    endcase
  endfunction

  always_comb begin
    sample_valid  = $onehot(~row_drv) && $onehot(~col_in);
    row_idx       = zero_pos(row_drv);
    col_idx       = zero_pos(col_in);
    sample_match  = sample_valid && (row_idx == row_q) && (col_idx == col_q);
    cols_released = (col_in == 4'b1111);
    cnt_d         = cnt_q + 4'd1;
  end

  // NOTE: all state uses non-blocking assignments so every register samples
  // the pre-edge values; blocking here would chain updates within one edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= SCAN;
      cnt_q       <= 4'd0;
      row_q       <= 2'd0;
      col_q       <= 2'd0;
      key_code_q  <= 4'h0;
      key_valid_q <= 1'b0;
    end else begin
      key_valid_q <= 1'b0;
      case (state_q)
        // Capture is clock-driven so the scanner is frozen on the very row it drove.
        SCAN: begin
          if (sample_valid) begin
            row_q   <= row_idx;
            col_q   <= col_idx;
            cnt_q   <= 4'd0;
            state_q <= DEBOUNCE;
          end
        end
        DEBOUNCE: begin
          if (tick) begin
            if (sample_match) begin
              cnt_q <= cnt_d;
              if (cnt_d == DB_TICKS) begin
                key_code_q  <= code_of(row_q, col_q);
                key_valid_q <= 1'b1;
                state_q     <= PRESSED;
              end
            end else begin
              state_q <= SCAN;
            end
          end
        end
        PRESSED: begin
          if (tick && cols_released) begin
            cnt_q   <= 4'd0;
            state_q <= RELEASE;
          end
        end
        RELEASE: begin
          if (tick) begin
            if (cols_released) begin
              cnt_q <= cnt_d;
              if (cnt_d == DB_TICKS) state_q <= SCAN;
            end else begin
              state_q <= PRESSED;
            end
          end
        end
        default: state_q <= SCAN;
      endcase
    end
  end

  // Any valid sample in SCAN freezes the scanner in the same cycle it is seen.
  assign scan_en   = (state_q == SCAN) && !sample_valid;
  assign key_held  = (state_q == PRESSED) || (state_q == RELEASE);
  assign key_code  = key_code_q;
  assign key_valid = key_valid_q;

endmodule

// File: tb/tb_keypad_decoder.sv
// Directed bench for keypad_decoder: a vector table for single-cycle behaviour
// plus hand-written sequences for long holds and reset during debounce.
module tb_keypad_decoder;

  logic       clk = 1'b0;
  logic       rst;
  logic       tick;
  logic [3:0] row_drv;
  logic [3:0] col_in;
  logic       scan_en;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_held;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  keypad_decoder #(.DEBOUNCE_TICKS(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .tick      (tick),
    .row_drv   (row_drv),
    .col_in    (col_in),
    .scan_en   (scan_en),
    .key_code  (key_code),
    .key_valid (key_valid),
    .key_held  (key_held)
  );

  // en is scan_en just before the edge; valid/held/code are checked after it.
  typedef struct {
    logic       tick;
    logic [3:0] row;
    logic [3:0] col;
    logic       en;
    logic       valid;
    logic       held;
    logic [3:0] code;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic t, input logic [3:0] r, input logic [3:0] c,
                              input logic en, input logic v, input logic h,
                              input logic [3:0] code);
    vec_t x;
    x.tick = t; x.row = r; x.col = c; x.en = en; x.valid = v; x.held = h; x.code = code;
    vecs.push_back(x);
  endfunction

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic cyc(input logic t, input logic [3:0] r, input logic [3:0] c);
    @(negedge clk);
    tick = t; row_drv = r; col_in = c;
    #1;
  endtask

  task automatic edge_wait();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int pulses, held_bad, en_bad;

    // Key 6 (row1/col2) pressed for 4 ticks, then a clean release
    add(0, 4'b1101, 4'b1011, 0, 0, 0, 4'h0);
    add(1, 4'b1101, 4'b1011, 0, 0, 0, 4'h0);
    add(1, 4'b1101, 4'b1011, 0, 0, 0, 4'h0);
    add(1, 4'b1101, 4'b1011, 0, 0, 0, 4'h0);
    add(1, 4'b1101, 4'b1011, 0, 1, 1, 4'h6);
    add(0, 4'b1101, 4'b1011, 0, 0, 1, 4'h6);
    add(1, 4'b1101, 4'b1111, 0, 0, 1, 4'h6);
    add(1, 4'b1101, 4'b1111, 0, 0, 1, 4'h6);
    add(1, 4'b1101, 4'b1111, 0, 0, 1, 4'h6);
    add(1, 4'b1101, 4'b1111, 0, 0, 1, 4'h6);
    add(1, 4'b1101, 4'b1111, 0, 0, 0, 4'h6);
    add(0, 4'b1101, 4'b1111, 1, 0, 0, 4'h6);
    // Press bounce on tick 2 aborts to SCAN
    add(0, 4'b0111, 4'b1110, 0, 0, 0, 4'h6);
    add(1, 4'b0111, 4'b1110, 0, 0, 0, 4'h6);
    add(1, 4'b0111, 4'b1111, 0, 0, 0, 4'h6);
    add(0, 4'b0111, 4'b1111, 1, 0, 0, 4'h6);
    // Multi-key columns and a bad row drive are ignored
    add(0, 4'b1110, 4'b1100, 1, 0, 0, 4'h6);
    add(1, 4'b1110, 4'b1100, 1, 0, 0, 4'h6);
    add(0, 4'b1100, 4'b1110, 1, 0, 0, 4'h6);
    // Key 2 with idle cycles between ticks
    add(0, 4'b1110, 4'b1101, 0, 0, 0, 4'h6);
    add(0, 4'b1110, 4'b1101, 0, 0, 0, 4'h6);
    add(1, 4'b1110, 4'b1101, 0, 0, 0, 4'h6);
    add(0, 4'b1110, 4'b1101, 0, 0, 0, 4'h6);
    add(1, 4'b1110, 4'b1101, 0, 0, 0, 4'h6);
    add(1, 4'b1110, 4'b1101, 0, 0, 0, 4'h6);
    add(0, 4'b1110, 4'b1101, 0, 0, 0, 4'h6);
    add(1, 4'b1110, 4'b1101, 0, 1, 1, 4'h2);
    // Second key while held is ignored
    add(1, 4'b1110, 4'b1100, 0, 0, 1, 4'h2);
    add(1, 4'b1011, 4'b0111, 0, 0, 1, 4'h2);
    // Release glitch on release tick 2, then a clean release
    add(1, 4'b1110, 4'b1111, 0, 0, 1, 4'h2);
    add(1, 4'b1110, 4'b1111, 0, 0, 1, 4'h2);
    add(1, 4'b1110, 4'b1101, 0, 0, 1, 4'h2);
    add(1, 4'b1110, 4'b1111, 0, 0, 1, 4'h2);
    add(1, 4'b1110, 4'b1111, 0, 0, 1, 4'h2);
    add(1, 4'b1110, 4'b1111, 0, 0, 1, 4'h2);
    add(1, 4'b1110, 4'b1111, 0, 0, 1, 4'h2);
    add(1, 4'b1110, 4'b1111, 0, 0, 0, 4'h2);
    add(0, 4'b1110, 4'b1111, 1, 0, 0, 4'h2);

    rst = 1'b1; tick = 1'b0; row_drv = 4'b1110; col_in = 4'b1111;
    repeat (2) @(posedge clk);
    #1;
    check("reset.key_valid", 4'(key_valid), 4'h0);
    check("reset.key_held", 4'(key_held), 4'h0);
    check("reset.key_code", key_code, 4'h0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("reset.scan_en", 4'(scan_en), 4'h1);

    for (int i = 0; i < vecs.size(); i++) begin
      cyc(vecs[i].tick, vecs[i].row, vecs[i].col);
      check($sformatf("vec%0d.scan_en", i), 4'(scan_en), 4'(vecs[i].en));
      edge_wait();
      check($sformatf("vec%0d.key_valid", i), 4'(key_valid), 4'(vecs[i].valid));
      check($sformatf("vec%0d.key_held", i), 4'(key_held), 4'(vecs[i].held));
      check($sformatf("vec%0d.key_code", i), key_code, vecs[i].code);
    end

    // Key * (0xE) held for 50 ticks
    pulses = 0; held_bad = 0; en_bad = 0;
    cyc(0, 4'b0111, 4'b1110);
    check("hold.capture_scan_en", 4'(scan_en), 4'h0);
    edge_wait();
    for (int i = 0; i < 50; i++) begin
      cyc(1, 4'b0111, 4'b1110);
      if (scan_en !== 1'b0) en_bad++;
      edge_wait();
      if (key_valid === 1'b1) pulses++;
      if (i >= 3 && key_held !== 1'b1) held_bad++;
    end
    check("hold.pulses", 4'(pulses), 4'h1);
    check("hold.key_code", key_code, 4'hE);
    check("hold.held_drops", 4'(held_bad), 4'h0);
    for (int i = 0; i < 3; i++) begin
      cyc(1, 4'b0111, 4'b1111);
      if (scan_en !== 1'b0) en_bad++;
      edge_wait();
    end
    cyc(1, 4'b0111, 4'b1111);
    check("hold.rel3_scan_en", 4'(scan_en), 4'h0);
    check("hold.rel3_key_held", 4'(key_held), 4'h1);
    edge_wait();
    cyc(1, 4'b0111, 4'b1111);
    edge_wait();
    check("hold.scan_en_highs", 4'(en_bad), 4'h0);
    cyc(0, 4'b0111, 4'b1111);
    check("hold.done_scan_en", 4'(scan_en), 4'h1);
    check("hold.done_key_held", 4'(key_held), 4'h0);

    // Reset on the third debounce tick of key C
    cyc(0, 4'b1011, 4'b0111);
    check("rstdb.capture_scan_en", 4'(scan_en), 4'h0);
    edge_wait();
    cyc(1, 4'b1011, 4'b0111); edge_wait();
    cyc(1, 4'b1011, 4'b0111); edge_wait();
    cyc(1, 4'b1011, 4'b0111);
    rst = 1'b1;
    edge_wait();
    check("rstdb.key_valid", 4'(key_valid), 4'h0);
    check("rstdb.key_held", 4'(key_held), 4'h0);
    check("rstdb.key_code", key_code, 4'h0);
    cyc(1, 4'b1011, 4'b1111);
    rst = 1'b0;
    check("rstdb.scan_en", 4'(scan_en), 4'h1);
    edge_wait();
    check("rstdb.after_key_valid", 4'(key_valid), 4'h0);
    check("rstdb.after_key_held", 4'(key_held), 4'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
